// File: rtl/prg_cnt.sv
// rtl/prg_cnt.sv - program counter with load, relative branch, stall and optional return stack
// Optional return-address stack compiled in by PRG_CNT_STACK_EN.
module prg_cnt #(
  parameter int WIDTH       = 8,
  parameter int RESET_ADDR  = 0,
  parameter int STEP        = 1,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_add,
  input  logic             stall,
  input  logic             br,
  input  logic [WIDTH-1:0] br_off,
`ifdef PRG_CNT_STACK_EN
  input  logic             call,
  input  logic             ret,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             stk_err,
`endif
  output logic [WIDTH-1:0] add_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_ADDR);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   br_sum;
  logic             br_wrap;
  logic [WIDTH-1:0] pc_nxt;
  logic             wrap_nxt;

  assign inc_sum = {1'b0, add_out} + {1'b0, STEP_W};
  assign br_sum  = {1'b0, add_out} + {1'b0, br_off};
  // A negative offset borrows past zero exactly when the unsigned add produces no carry.
  assign br_wrap = br_off[WIDTH-1] ? ~br_sum[WIDTH] : br_sum[WIDTH];

`ifdef PRG_CNT_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [WIDTH-1:0] stack [0:STACK_DEPTH-1];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_nxt;
  logic             push;
  logic             err_nxt;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == SP_W'(STACK_DEPTH));
`endif

  always_comb begin
    pc_nxt   = add_out;
    wrap_nxt = 1'b0;
    if (ld) begin
      pc_nxt = ld_add;
    end else if (br) begin
      pc_nxt   = br_sum[WIDTH-1:0];
      wrap_nxt = br_wrap;
    end else if (!stall) begin
      pc_nxt   = inc_sum[WIDTH-1:0];
      wrap_nxt = inc_sum[WIDTH];
    end
`ifdef PRG_CNT_STACK_EN
    sp_nxt  = sp;
    push    = 1'b0;
    err_nxt = 1'b0;
    if (ret) begin
      if (is_empty) begin
        pc_nxt   = inc_sum[WIDTH-1:0];
        wrap_nxt = inc_sum[WIDTH];
        err_nxt  = 1'b1;
      end else begin
        pc_nxt   = stack[IDX_W'(sp - 1'b1)];
        wrap_nxt = 1'b0;
        sp_nxt   = sp - 1'b1;
      end
    end else if (call) begin
      pc_nxt   = ld_add;
      wrap_nxt = 1'b0;
      if (is_full) begin
        err_nxt = 1'b1;
      end else begin
        push   = 1'b1;
        sp_nxt = sp + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      add_out <= RESET_W;
      wrap    <= 1'b0;
    end else begin
      add_out <= pc_nxt;
      wrap    <= wrap_nxt;
    end
  end

`ifdef PRG_CNT_STACK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp        <= '0;
      stk_empty <= 1'b1;
      stk_full  <= 1'b0;
      stk_err   <= 1'b0;
    end else begin
      sp        <= sp_nxt;
      stk_empty <= (sp_nxt == '0);
      stk_full  <= (sp_nxt == SP_W'(STACK_DEPTH));
      stk_err   <= err_nxt;
    end
  end

  // Entries carry no reset; occupancy is tracked solely by sp.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      stack[IDX_W'(sp)] <= inc_sum[WIDTH-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_prg_cnt.sv
// tb/tb_prg_cnt.sv - directed self-checking bench for prg_cnt
// Stack scenarios are included when PRG_CNT_STACK_EN is defined.
module tb_prg_cnt;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld;
  logic [7:0] ld_add;
  logic       stall;
  logic       br;
  logic [7:0] br_off;
  logic [7:0] add_out;
  logic       wrap;
`ifdef PRG_CNT_STACK_EN
  logic       call;
  logic       ret;
  logic       stk_empty;
  logic       stk_full;
  logic       stk_err;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  prg_cnt dut (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .ld_add    (ld_add),
    .stall     (stall),
    .br        (br),
    .br_off    (br_off),
`ifdef PRG_CNT_STACK_EN
    .call      (call),
    .ret       (ret),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .stk_err   (stk_err),
`endif
    .add_out   (add_out),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic step_pc(input string tag, input logic [7:0] exp_pc, input logic exp_wrap);
    step();
    check({tag, ".pc"}, 16'(add_out), 16'(exp_pc));
    check({tag, ".wrap"}, 16'(wrap), 16'(exp_wrap));
  endtask

  initial begin
    rst = 1'b0; ld = 1'b0; ld_add = 8'h00; stall = 1'b0; br = 1'b0; br_off = 8'h00;
`ifdef PRG_CNT_STACK_EN
    call = 1'b0; ret = 1'b0;
`endif
    #2;

    // 1: reset and count
    step_pc("rst0", 8'h00, 1'b0);
    step_pc("rst1", 8'h00, 1'b0);
`ifdef PRG_CNT_STACK_EN
    check("rst.empty", 16'(stk_empty), 16'h1);
    check("rst.full", 16'(stk_full), 16'h0);
    check("rst.err", 16'(stk_err), 16'h0);
`endif
    rst = 1'b1;
    step_pc("cnt1", 8'h01, 1'b0);
    step_pc("cnt2", 8'h02, 1'b0);
    step_pc("cnt3", 8'h03, 1'b0);

    // 2: load then reset restart
    ld = 1'b1; ld_add = 8'h0A;
    step_pc("ld0a", 8'h0A, 1'b0);
    ld = 1'b0;
    step_pc("ld0b", 8'h0B, 1'b0);
    step_pc("ld0c", 8'h0C, 1'b0);
    rst = 1'b0;
    step_pc("rst_mid", 8'h00, 1'b0);
    rst = 1'b1;
    step_pc("restart", 8'h01, 1'b0);

    // 3: wrap and branch
    ld = 1'b1; ld_add = 8'hFE;
    step_pc("ldfe", 8'hFE, 1'b0);
    ld = 1'b0;
    step_pc("cntff", 8'hFF, 1'b0);
    step_pc("wrap00", 8'h00, 1'b1);
    step_pc("post_wrap", 8'h01, 1'b0);
    ld = 1'b1; ld_add = 8'h10;
    step_pc("ld10", 8'h10, 1'b0);
    ld = 1'b0; br = 1'b1; br_off = 8'hFC;
    step_pc("br_back", 8'h0C, 1'b0);
    br = 1'b0; ld = 1'b1; ld_add = 8'h02;
    step_pc("ld02", 8'h02, 1'b0);
    ld = 1'b0; br = 1'b1; br_off = 8'hFC;
    step_pc("br_under", 8'hFE, 1'b1);
    br_off = 8'h05;
    step_pc("br_over", 8'h03, 1'b1);
    br = 1'b0;
    step_pc("br_resume", 8'h04, 1'b0);

    // 4: stall and priority
    ld = 1'b1; ld_add = 8'h20;
    step_pc("ld20", 8'h20, 1'b0);
    ld = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) step_pc("stall", 8'h20, 1'b0);
    stall = 1'b0;
    step_pc("unstall", 8'h21, 1'b0);
    stall = 1'b1; ld = 1'b1; ld_add = 8'h40;
    step_pc("stall_ld", 8'h40, 1'b0);
    ld = 1'b0; br = 1'b1; br_off = 8'h02;
    step_pc("stall_br", 8'h42, 1'b0);
    stall = 1'b0; br = 1'b0;
    rst = 1'b0; ld = 1'b1; ld_add = 8'h55;
    step_pc("rst_ld", 8'h00, 1'b0);
    rst = 1'b1; ld = 1'b0;
    step_pc("rst_ld_rel", 8'h01, 1'b0);

`ifdef PRG_CNT_STACK_EN
    // 5: return stack
    ld = 1'b1; ld_add = 8'h05;
    step_pc("ld05", 8'h05, 1'b0);
    ld = 1'b0; call = 1'b1; ld_add = 8'h80;
    step_pc("call80", 8'h80, 1'b0);
    check("call.empty", 16'(stk_empty), 16'h0);
    call = 1'b0;
    step_pc("after_call", 8'h81, 1'b0);
    ret = 1'b1;
    step_pc("ret06", 8'h06, 1'b0);
    check("ret.empty", 16'(stk_empty), 16'h1);
    ret = 1'b0;
    for (int i = 0; i < 5; i++) begin
      call = 1'b1; ld_add = 8'h90 + 8'(i);
      step_pc("call_n", 8'h90 + 8'(i), 1'b0);
      check("call_n.full", 16'(stk_full), 16'(i >= 3));
      check("call_n.err", 16'(stk_err), 16'(i == 4));
    end
    call = 1'b0; ret = 1'b1;
    step_pc("ret93", 8'h93, 1'b0);
    check("ret93.full", 16'(stk_full), 16'h0);
    step_pc("ret92", 8'h92, 1'b0);
    step_pc("ret91", 8'h91, 1'b0);
    step_pc("ret07", 8'h07, 1'b0);
    check("ret07.empty", 16'(stk_empty), 16'h1);
    check("ret07.err", 16'(stk_err), 16'h0);
    step_pc("ret_empty", 8'h08, 1'b0);
    check("ret_empty.err", 16'(stk_err), 16'h1);
    ret = 1'b0;
    step_pc("err_clear", 8'h09, 1'b0);
    check("err_clear.err", 16'(stk_err), 16'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/prg_cnt.md
# prg_cnt

Program counter for the processor front end. It holds the current instruction address and advances it by a fixed step every clock. It also supports absolute loads, PC-relative branches and stalls, plus an optional return-address stack. Its output `add_out` drives the instruction-memory address bus directly from a register.

## Interface
Parameters:
- `WIDTH`, 8: address width in bits.
- `RESET_ADDR`, 0: value loaded into `add_out` by reset.
- `STEP`, 1: increment per advancing cycle.
- `STACK_DEPTH`, 4: return-stack entries; used only with `PRG_CNT_STACK_EN`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-low.
- `ld`, input, 1: load `ld_add` into the PC.
- `ld_add`, input, WIDTH: absolute load or call target.
- `stall`, input, 1: hold the PC. Tie to 0 when unused.
- `br`, input, 1: relative branch. Tie to 0 when unused.
- `br_off`, input, WIDTH: two's-complement branch offset.
- `add_out`, output, WIDTH: current PC. Registered, no combinational path from inputs.
- `wrap`, output, 1: one-cycle pulse when an increment or branch crosses the top of the address space.
- With `PRG_CNT_STACK_EN` only:
  - `call`, input, 1: push the return address and jump to `ld_add`.
  - `ret`, input, 1: pop the stack into the PC.
  - `stk_empty`, output, 1: stack holds no entries.
  - `stk_full`, output, 1: stack holds `STACK_DEPTH` entries.
  - `stk_err`, output, 1: one-cycle pulse on overflow or underflow.

## Operation
- The next-PC selector is a fixed priority chain, highest first:
  - `rst` low: `add_out` = `RESET_ADDR`.
  - `ret` (macro builds only).
  - `call` (macro builds only).
  - `ld`: `add_out` = `ld_add`.
  - `br`: `add_out` = `add_out` + sign-extended `br_off`, modulo 2^WIDTH.
  - `stall`: `add_out` is held.
  - Otherwise: `add_out` = `add_out` + `STEP`, modulo 2^WIDTH.
- `wrap` asserts when the unsigned sum from an increment or branch overflows or underflows WIDTH bits.
  - It is not asserted for `ld`, `call`, `ret` or reset.
- `ld` and `call` are single-cycle commands. A level held high reloads the same value on every edge.
- Unknown or undriven control inputs carry no defined behaviour. Benches must drive them to 0 or 1.

## Timing
- Reset state, after any rising edge with `rst` low:
  - `add_out` = `RESET_ADDR`, `wrap` = 0.
  - With the macro: stack pointer = 0, `stk_empty` = 1, `stk_full` = 0, `stk_err` = 0.
- Reset overrides every other input on the same edge.
- Asserting reset mid-sequence discards any pending load or branch.
- Latency:
  - A command sampled at edge N is visible on `add_out` immediately after edge N.
  - Counting resumes at edge N+1.
  - Example: `ld` with `ld_add`=0x0A gives 0x0A, then 0x0B, 0x0C, ...
- On the first edge after `rst` returns high with no command, `add_out` = `RESET_ADDR` + `STEP`.
- Wrap example, WIDTH=8, STEP=1: 0xFF is followed by 0x00, with `wrap` high for that single cycle.
- `stall` together with `ld` or `br` on the same edge: the load or branch wins.

## Configuration
- Macro `PRG_CNT_STACK_EN`, when defined, compiles in the return-address stack, a LIFO of `STACK_DEPTH` entries of WIDTH bits.
  - `call`: push `add_out` + `STEP`, then `add_out` = `ld_add`.
  - `ret`: `add_out` = top entry, then pop.
  - `ret` and `call` on the same edge: `ret` wins and `call` is ignored.
  - `call` while full: the jump still occurs, the push is dropped, the stack is unchanged, and `stk_err` pulses.
  - `ret` while empty: the PC increments normally and `stk_err` pulses.
  - `stk_empty` and `stk_full` are registered and reflect the stack occupancy after each edge.
- When the macro is undefined:
  - The `call`, `ret`, `stk_empty`, `stk_full` and `stk_err` ports do not exist.
  - `STACK_DEPTH` is ignored.
  - The block contains no stack storage.

## Test plan
All scenarios use default parameters.
1. Reset and count: hold `rst` low for 2 edges, then release with no commands. Required: `add_out` = 0x00 during reset, then 0x01, 0x02, 0x03 on successive edges.
2. Load: assert `ld` for one cycle with `ld_add`=0x0A, with setup at the falling edge. Required: `add_out` = 0x0A after the next rising edge, then 0x0B, 0x0C. Then pull `rst` low for one edge. Required: `add_out` = 0x00, and counting restarts at 0x01.
3. Wrap and branch:
   - Load 0xFE, then let it count. Required: 0xFF, then 0x00 with `wrap`=1 for exactly one cycle.
   - From 0x10, assert `br` with `br_off`=0xFC. Required: `add_out` = 0x0C.
4. Stall and priority:
   - Assert `stall` for 3 cycles at 0x20. Required: `add_out` stays 0x20, then resumes at 0x21.
   - Assert `stall` together with `ld`, `ld_add`=0x40. Required: `add_out` = 0x40.
   - Assert `rst` low together with `ld`. Required: `add_out` = 0x00.
5. Stack (macro builds only):
   - From 0x05, assert `call` with `ld_add`=0x80. Required: `add_out` = 0x80.
   - Later `ret`. Required: `add_out` = 0x06.
   - Make 5 calls. Required: `stk_full`=1 and `stk_err` pulses on the 5th.
   - `ret` while empty. Required: `add_out` increments and `stk_err` pulses.
